// File: rtl/scan_ctrl_if.sv
// Read-request bus towards the image buffer plus the downstream pixel stream.
// The master side is the scan sequencer; the slave side is the buffer/consumer.
interface scan_ctrl_if #(
   parameter int XW = 9,
   parameter int YW = 9,
   parameter int DW = 8
);
   // image buffer read channel
   logic          rd_req;
   logic [XW-1:0] rd_x;
   logic [YW-1:0] rd_y;
   logic          rd_ack;
   logic          rd_valid;
   logic [DW-1:0] rd_data;

   // downstream pixel channel
   logic          px_valid;
   logic          px_ready;
   logic [DW-1:0] px_data;
   logic [XW-1:0] px_x;
   logic [YW-1:0] px_y;
   logic          px_last;

   modport master (
      output rd_req, rd_x, rd_y,
      input  rd_ack, rd_valid, rd_data,
      output px_valid, px_data, px_x, px_y, px_last,
      input  px_ready
   );

   modport slave (
      input  rd_req, rd_x, rd_y,
      output rd_ack, rd_valid, rd_data,
      input  px_valid, px_data, px_x, px_y, px_last,
      output px_ready
   );
endinterface

// File: rtl/scan_ctrl.sv
// Frame-scan sequencer: walks a pixel_pos instance over one image, fetching
// each pixel from the image buffer and handing it downstream with valid/ready.
// Scan order is owned by pixel_pos; coordinates are only passed through here.
module scan_ctrl #(
   parameter int X_MAX = 300,
   parameter int Y_MAX = 300,
   parameter int DW    = 8,
   localparam int XW   = $clog2(X_MAX),
   localparam int YW   = $clog2(Y_MAX)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          start,
   input  logic [XW-1:0] cfg_x,
   input  logic [YW-1:0] cfg_y,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          pp_new_trans,
   output logic          pp_update_pos,
   output logic [XW-1:0] pp_max_x,
   output logic [YW-1:0] pp_max_y,
   input  logic          pp_end_pos,
   input  logic [XW-1:0] pp_curr_x,
   input  logic [YW-1:0] pp_curr_y,
   scan_ctrl_if.master   bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETTLE, S_REQ, S_WAIT, S_OUT, S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [XW-1:0] max_x_q, max_x_d;
   logic [YW-1:0] max_y_q, max_y_d;
   logic          err_q, err_d;
   logic [XW-1:0] px_x_q, px_x_d;
   logic [YW-1:0] px_y_q, px_y_d;
   logic          px_last_q, px_last_d;
   logic [DW-1:0] px_data_q, px_data_d;
   logic          start_acc;

   // abort outranks start, so a start in the same cycle as abort is dropped
   assign start_acc = (state_q == S_IDLE) && start && !abort;

   // state register
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode; abort forces IDLE from anywhere
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start)    state_d = S_LOAD;
         S_LOAD:                 state_d = S_SETTLE;
         S_SETTLE:               state_d = S_REQ;
         S_REQ:    if (bus.rd_ack)   state_d = S_WAIT;
         S_WAIT:   if (bus.rd_valid) state_d = S_OUT;
         S_OUT:    if (bus.px_ready) state_d = px_last_q ? S_DONE : S_REQ;
         S_DONE:                 state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d = S_IDLE;
      end
   end

   // datapath registers: frame size, sticky error, captured pixel
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         max_x_q   <= '0;
         max_y_q   <= '0;
         err_q     <= 1'b0;
         px_x_q    <= '0;
         px_y_q    <= '0;
         px_last_q <= 1'b0;
         px_data_q <= '0;
      end else begin
         max_x_q   <= max_x_d;
         max_y_q   <= max_y_d;
         err_q     <= err_d;
         px_x_q    <= px_x_d;
         px_y_q    <= px_y_d;
         px_last_q <= px_last_d;
         px_data_q <= px_data_d;
      end
   end

   // datapath next values; a stray rd_valid wins over the start-time clear
   always_comb begin
      max_x_d   = max_x_q;
      max_y_d   = max_y_q;
      err_d     = err_q;
      px_x_d    = px_x_q;
      px_y_d    = px_y_q;
      px_last_d = px_last_q;
      px_data_d = px_data_q;
      if (start_acc) begin
         max_x_d = cfg_x;
         max_y_d = cfg_y;
         err_d   = 1'b0;
      end
      if (bus.rd_valid && (state_q != S_WAIT)) begin
         err_d = 1'b1;
      end
      if ((state_q == S_REQ) && bus.rd_ack) begin
         px_x_d    = pp_curr_x;
         px_y_d    = pp_curr_y;
         px_last_d = pp_end_pos;
      end
      if ((state_q == S_WAIT) && bus.rd_valid) begin
         px_data_d = bus.rd_data;
      end
   end

   // outputs decoded from the registered state; update_pos is the only
   // one that also looks at the live handshake
   always_comb begin
      busy          = (state_q != S_IDLE);
      done          = (state_q == S_DONE);
      pp_new_trans  = (state_q == S_LOAD);
      pp_update_pos = (state_q == S_OUT) && bus.px_ready && !px_last_q && !abort;
      bus.rd_req    = (state_q == S_REQ);
      bus.rd_x      = (state_q == S_REQ) ? pp_curr_x : '0;
      bus.rd_y      = (state_q == S_REQ) ? pp_curr_y : '0;
      bus.px_valid  = (state_q == S_OUT);
   end

   assign err          = err_q;
   assign pp_max_x     = max_x_q;
   assign pp_max_y     = max_y_q;
   assign bus.px_x     = px_x_q;
   assign bus.px_y     = px_y_q;
   assign bus.px_last  = px_last_q;
   assign bus.px_data  = px_data_q;

endmodule
